// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, sync-ROM request, valid/ready delivery to the decoder.
// Latency: request in cycle N, inst_valid in cycle N+2; one instruction per cycle while ready.
// Backpressure: output register plus one-entry skid; issue stalls once two entries are committed.
module inst_fetch #(
    parameter int                    PC_WIDTH    = 8,
    parameter int                    INST_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = 4'b1111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  halted
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            state;
    logic [PC_WIDTH-1:0]   pc;
    logic                  rsp_pending;
    logic [PC_WIDTH-1:0]   rsp_pc;
    logic                  out_valid;
    logic [INST_WIDTH-1:0] out_inst;
    logic [PC_WIDTH-1:0]   out_pc;
    logic                  skid_valid;
    logic [INST_WIDTH-1:0] skid_inst;
    logic [PC_WIDTH-1:0]   skid_pc;

    logic       accept;
    logic       out_free;
    logic       halt_rsp;
    logic       rsp_wr;
    logic [2:0] occ;
    logic [2:0] occ_after;
    logic       issue;

    assign accept    = out_valid & inst_ready;
    assign out_free  = ~out_valid | accept;
    assign halt_rsp  = rsp_pending & (imem_rdata[INST_WIDTH-1:INST_WIDTH-4] == HALT_OPCODE);
    assign rsp_wr    = rsp_pending & ~halt_rsp & ~redirect_valid;
    assign occ       = {2'b00, out_valid} + {2'b00, skid_valid} + {2'b00, rsp_pending};
    assign occ_after = occ - {2'b00, accept};
    assign issue     = (state == ST_FETCH) & ~redirect_valid & ~halt_rsp & (occ_after < 3'd2);

    // Gated by rst_n so no request is visible while reset is held.
    assign imem_en   = issue & rst_n;
    assign imem_addr = pc;

    assign inst_valid  = out_valid;
    assign instruction = out_inst;
    assign inst_pc     = out_pc;
    assign halted      = (state == ST_HALT) & ~out_valid & ~skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            rsp_pending <= 1'b0;
            rsp_pc      <= '0;
        end else if (redirect_valid) begin
            state       <= ST_FETCH;
            pc          <= redirect_pc;
            rsp_pending <= 1'b0;
        end else begin
            if (halt_rsp) begin
                state <= ST_HALT;
            end
            rsp_pending <= issue;
            if (issue) begin
                pc     <= pc + PC_ONE;
                rsp_pc <= pc;
            end
        end
    end

    // Skid contents always move to the output before a fresh response does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (redirect_valid) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_inst   <= skid_inst;
                out_pc     <= skid_pc;
                skid_valid <= rsp_wr;
                if (rsp_wr) begin
                    skid_inst <= imem_rdata;
                    skid_pc   <= rsp_pc;
                end
            end else if (rsp_wr) begin
                out_valid <= 1'b1;
                out_inst  <= imem_rdata;
                out_pc    <= rsp_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (rsp_wr) begin
            skid_valid <= 1'b1;
            skid_inst  <= imem_rdata;
            skid_pc    <= rsp_pc;
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage for the 16-bit single-cycle datapath. It sits directly upstream of the instruction decoder.
- Holds the PC and drives a synchronous-read instruction ROM.
- Presents each 16-bit instruction and its PC to the decoder over a valid/ready handshake.
- Absorbs backpressure with a one-entry skid buffer.
- Supports PC redirect (branch/jump resolution) and a halt opcode that stops fetching.

Parameters:
PC_WIDTH, 8, width of PC and instruction-memory word address
INST_WIDTH, 16, instruction width; opcode is [INST_WIDTH-1:INST_WIDTH-4]
RESET_PC, 0, PC loaded on reset
HALT_OPCODE, 4'b1111, opcode that stops fetch; unused by the decoder

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_en  out  1  read request this cycle
imem_addr  out  PC_WIDTH  word address of the request
imem_rdata  in  INST_WIDTH  ROM data, valid the cycle after imem_en
redirect_valid  in  1  load redirect_pc and flush the stage
redirect_pc  in  PC_WIDTH  new fetch address
inst_valid  out  1  instruction/inst_pc valid for the decoder
inst_ready  in  1  decoder accepts this cycle
instruction  out  INST_WIDTH  instruction to the decoder
inst_pc  out  PC_WIDTH  address of the presented instruction
halted  out  1  halt reached and stage drained

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=FETCH, rsp_pending=0, skid_valid=0.
- Output reset values: inst_valid=0, instruction=0, inst_pc=0, halted=0, imem_en=0, imem_addr=RESET_PC.
- Reset mid-operation: everything returns to reset values immediately. Responses in flight are discarded.
- States:
  - FETCH: issuing requests.
  - HALT: no requests issued.
- Occupancy occ = inst_valid + skid_valid + rsp_pending.
- Issue condition: state==FETCH, no redirect, no halt response this cycle, and (occ - (inst_valid & inst_ready)) < 2.
- On issue:
  - imem_en=1 and imem_addr=pc, combinational from the pc register.
  - pc <= pc+1 modulo 2^PC_WIDTH; 0xFF wraps to 0x00.
  - rsp_pending <= 1, tagged with the issued address.
- Response handling: when rsp_pending, imem_rdata is valid this cycle and is written to the first free slot.
  - The output register is used if empty or being accepted; otherwise the skid buffer.
  - The skid buffer never overflows; the issue rule guarantees this.
- Ordering:
  - The skid buffer always refills the output register before any new response.
  - Instructions leave strictly in PC order. None are dropped or duplicated.
- Handshake:
  - An instruction transfers when inst_valid & inst_ready.
  - While inst_valid=1 and inst_ready=0, instruction and inst_pc hold stable.
- Throughput: one instruction per cycle while inst_ready=1.
- Latency: request in cycle N, inst_valid in cycle N+2.
- Redirect (highest priority, any state):
  - Effects: pc <= redirect_pc; inst_valid, skid_valid and rsp_pending cleared; state <= FETCH; halted <= 0.
  - No issue that cycle. The first request to redirect_pc goes out the next cycle.
  - An instruction being accepted in the same cycle as a redirect still counts as transferred.
- Halt:
  - When a response carries opcode==HALT_OPCODE, it is not enqueued.
  - state <= HALT and no issue occurs that cycle.
  - Instructions already buffered still drain.
  - halted=1 when state==HALT, inst_valid=0 and skid_valid=0. It stays 1 until redirect or reset.

Test Plan:
- Stream: ROM[0..3]={0x3105,0x2640,0x1203,0x0101}, inst_ready=1 after reset release.
  -> inst_valid rises in cycle 2.
  -> inst_pc 0,1,2,3 on consecutive cycles with matching instructions.
- Backpressure: inst_ready=0 for cycles 4-7 mid-stream.
  -> instruction/inst_pc stable while stalled.
  -> imem_en=0 once occ=2.
  -> resumes with the next PC in order, with no gap or duplicate.
- Redirect: redirect_valid=1, redirect_pc=0x40 while a response is pending.
  -> pending data discarded.
  -> next presented inst_pc=0x40 two cycles after the first request to 0x40.
- Halt: ROM[5]=0xF000 with inst_ready=1.
  -> instructions 0-4 delivered; 0xF000 never presented.
  -> imem_en stays 0.
  -> halted=1 after drain.
  -> redirect to 0x00 clears halted and restarts.
- Wrap: RESET_PC=0xFE.
  -> inst_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-stall: rst_n low with skid full.
  -> all outputs at reset values immediately.
  -> after release, first inst_pc=RESET_PC.
